// File: rtl/invader_bullets.sv
// invader_bullets: spawns, steps and retires the invader swarm's downward bullets.
// Optional feature: define AIMED_FIRE_EN so that every fourth shot targets the player's column.
module invader_bullets #(
  parameter int NUM_BULLETS   = 3,
  parameter int NUM_COLS      = 11,
  parameter int COL_PITCH     = 32,
  parameter int COL_X_OFFSET  = 14,
  parameter int FIRE_INTERVAL = 48,
  parameter int BULLET_STEP   = 4,
  parameter int SCREEN_BOTTOM = 464
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame,
  input  logic                      game_active,
  input  logic [NUM_COLS-1:0]       column_alive,
  input  logic [9:0]                swarm_x,
  input  logic [9:0]                swarm_bottom_y,
  input  logic [9:0]                player_x,
  input  logic [NUM_BULLETS-1:0]    bullet_hit,
  output logic [NUM_BULLETS-1:0]    bullet_active,
  output logic [NUM_BULLETS*10-1:0] bullet_x,
  output logic [NUM_BULLETS*10-1:0] bullet_y
);

  localparam int CNT_W = $clog2(FIRE_INTERVAL + 1);
  localparam logic [NUM_BULLETS-1:0] SLOT_ONE = NUM_BULLETS'(1);

  logic [15:0]              lfsr_q, lfsr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_BULLETS-1:0]   active_q, active_d;
  logic [NUM_BULLETS*10-1:0] x_q, x_d, y_q, y_d;

  logic [15:0]            alive_ext;
  logic [3:0]             lfsr_col, col;
  logic [9:0]             spawn_x;
  logic [NUM_BULLETS-1:0] free_v, pick_v;
  logic                   attempt, spawn;

  assign alive_ext = 16'(column_alive);
  // Single fold only: with few columns the folded index can still be out of range and reads as dead.
  assign lfsr_col = ({1'b0, lfsr_q[3:0]} >= 5'(NUM_COLS)) ? lfsr_q[3:0] - 4'(NUM_COLS) : lfsr_q[3:0];

`ifdef AIMED_FIRE_EN
  logic [1:0]  shot_q, shot_d;
  logic [10:0] aim_diff;
  logic [9:0]  aim_quo;
  logic [3:0]  aim_col;

  always_comb begin
    aim_diff = {1'b0, player_x} - {1'b0, swarm_x};
    aim_quo  = aim_diff[9:0] / 10'(COL_PITCH);
    if (aim_diff[10])
      aim_col = 4'd0;
    else if (aim_quo >= 10'(NUM_COLS - 1))
      aim_col = 4'(NUM_COLS - 1);
    else
      aim_col = aim_quo[3:0];
  end

  assign col    = (shot_q == 2'd3 && alive_ext[aim_col]) ? aim_col : lfsr_col;
  assign shot_d = spawn ? shot_q + 2'd1 : shot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shot_q <= 2'd0;
    else        shot_q <= shot_d;
  end
`else
  logic unused_player_x;
  assign unused_player_x = ^player_x;
  assign col = lfsr_col;
`endif

  always_comb begin
    lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    spawn_x = swarm_x + 10'(col) * 10'(COL_PITCH) + 10'(COL_X_OFFSET);
    free_v  = ~active_q;
    pick_v  = free_v & (~free_v + SLOT_ONE);
    attempt = frame && (cnt_q == CNT_W'(FIRE_INTERVAL));
    // Free slots are judged on the flags before this frame's retirements.
    spawn   = game_active && attempt && alive_ext[col] && (|free_v);

    active_d = active_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;

    if (!game_active) begin
      active_d = '0;
      cnt_d    = '0;
    end else begin
      if (frame) begin
        if (!attempt)   cnt_d = cnt_q + CNT_W'(1);
        else if (spawn) cnt_d = '0;
      end
      for (int i = 0; i < NUM_BULLETS; i++) begin
        if (bullet_hit[i]) begin
          active_d[i] = 1'b0;
        end else if (frame && active_q[i]) begin
          if ({1'b0, y_q[10*i +: 10]} + 11'(BULLET_STEP) >= 11'(SCREEN_BOTTOM))
            active_d[i] = 1'b0;
          else
            y_d[10*i +: 10] = y_q[10*i +: 10] + 10'(BULLET_STEP);
        end
        if (spawn && pick_v[i]) begin
          active_d[i]     = 1'b1;
          x_d[10*i +: 10] = spawn_x;
          y_d[10*i +: 10] = swarm_bottom_y;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= 16'hACE1;
      cnt_q    <= '0;
      active_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

  assign bullet_active = active_q;
  assign bullet_x      = x_q;
  assign bullet_y      = y_q;

endmodule

// File: tb/tb_invader_bullets.sv
// Bench for invader_bullets: two instances (default and short fire interval) checked every cycle
// against a behavioural model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_invader_bullets;
  localparam int NB      = 3;
  localparam int NC      = 11;
  localparam int FI_SLOW = 48;
  localparam int FI_FAST = 8;
  localparam int PITCH   = 32;
  localparam int XOFF    = 14;
  localparam int STEP    = 4;
  localparam int BOTTOM  = 464;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic frame = 1'b0;
  logic game_active = 1'b0;
  logic [NC-1:0] column_alive = '0;
  logic [9:0] swarm_x = '0, swarm_bottom_y = '0, player_x = '0;
  logic [NB-1:0] bullet_hit = '0;
  logic [NB-1:0] act_s, act_f;
  logic [NB*10-1:0] x_s, y_s, x_f, y_f;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  invader_bullets u_slow (
    .clk(clk), .rst_n(rst_n), .frame(frame), .game_active(game_active),
    .column_alive(column_alive), .swarm_x(swarm_x), .swarm_bottom_y(swarm_bottom_y),
    .player_x(player_x), .bullet_hit(bullet_hit),
    .bullet_active(act_s), .bullet_x(x_s), .bullet_y(y_s));

  invader_bullets #(.FIRE_INTERVAL(FI_FAST)) u_fast (
    .clk(clk), .rst_n(rst_n), .frame(frame), .game_active(game_active),
    .column_alive(column_alive), .swarm_x(swarm_x), .swarm_bottom_y(swarm_bottom_y),
    .player_x(player_x), .bullet_hit(bullet_hit),
    .bullet_active(act_f), .bullet_x(x_f), .bullet_y(y_f));

  // Behavioural model: index 0 = u_slow, 1 = u_fast
  int m_act[2][NB];
  int m_x[2][NB];
  int m_y[2][NB];
  int m_cnt[2];
  int m_lfsr[2];
  int m_shot[2];
  int m_col[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NB; i++) begin
        m_act[k][i] = 0; m_x[k][i] = 0; m_y[k][i] = 0;
      end
      m_cnt[k] = 0; m_lfsr[k] = 'hACE1; m_shot[k] = 0; m_col[k] = 0;
    end
  endtask

  task automatic model_step(int k);
    int col, fi, free_s, b;
    bit spawn;
    fi = (k == 1) ? FI_FAST : FI_SLOW;
    col = m_lfsr[k] % 16;
    if (col >= NC) col = col - NC;
`ifdef AIMED_FIRE_EN
    if (m_shot[k] == 3) begin
      int d, a;
      d = int'(player_x) - int'(swarm_x);
      a = (d < 0) ? 0 : d / PITCH;
      if (a > NC - 1) a = NC - 1;
      if (column_alive[a]) col = a;
    end
`endif
    spawn = 1'b0;
    free_s = -1;
    if (!game_active) begin
      for (int i = 0; i < NB; i++) m_act[k][i] = 0;
      m_cnt[k] = 0;
    end else begin
      if (frame) begin
        if (m_cnt[k] < fi) m_cnt[k]++;
        else begin
          for (int i = NB - 1; i >= 0; i--) if (m_act[k][i] == 0) free_s = i;
          if (free_s >= 0 && col < NC && column_alive[col]) begin
            spawn = 1'b1;
            m_cnt[k] = 0;
            m_shot[k] = (m_shot[k] + 1) % 4;
            m_col[k] = col;
          end
        end
      end
      for (int i = 0; i < NB; i++) begin
        if (bullet_hit[i]) m_act[k][i] = 0;
        else if (frame && m_act[k][i] != 0) begin
          if (m_y[k][i] + STEP >= BOTTOM) m_act[k][i] = 0;
          else m_y[k][i] = m_y[k][i] + STEP;
        end
      end
      if (spawn) begin
        m_act[k][free_s] = 1;
        m_x[k][free_s] = (int'(swarm_x) + col * PITCH + XOFF) % 1024;
        m_y[k][free_s] = int'(swarm_bottom_y);
      end
    end
    b = (m_lfsr[k] ^ (m_lfsr[k] >> 2) ^ (m_lfsr[k] >> 3) ^ (m_lfsr[k] >> 5)) & 1;
    m_lfsr[k] = (m_lfsr[k] >> 1) | (b << 15);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  function automatic logic [NB-1:0] dut_act(int k);
    return (k == 1) ? act_f : act_s;
  endfunction
  function automatic logic [NB*10-1:0] dut_x(int k);
    return (k == 1) ? x_f : x_s;
  endfunction
  function automatic logic [NB*10-1:0] dut_yv(int k);
    return (k == 1) ? y_f : y_s;
  endfunction
  function automatic logic [9:0] dut_y(int k, int i);
    logic [NB*10-1:0] v;
    v = dut_yv(k);
    return v[10*i +: 10];
  endfunction
  function automatic logic [9:0] dut_xs(int k, int i);
    logic [NB*10-1:0] v;
    v = dut_x(k);
    return v[10*i +: 10];
  endfunction

  function automatic logic [NB-1:0] m_act_vec(int k);
    logic [NB-1:0] v;
    for (int i = 0; i < NB; i++) v[i] = (m_act[k][i] != 0);
    return v;
  endfunction
  function automatic logic [NB*10-1:0] m_x_vec(int k);
    logic [NB*10-1:0] v;
    for (int i = 0; i < NB; i++) v[10*i +: 10] = 10'(m_x[k][i]);
    return v;
  endfunction
  function automatic logic [NB*10-1:0] m_y_vec(int k);
    logic [NB*10-1:0] v;
    for (int i = 0; i < NB; i++) v[10*i +: 10] = 10'(m_y[k][i]);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("cyc_active_%0d", k), 32'(dut_act(k)), 32'(m_act_vec(k)));
        chk($sformatf("cyc_x_%0d", k), 32'(dut_x(k)), 32'(m_x_vec(k)));
        chk($sformatf("cyc_y_%0d", k), 32'(dut_yv(k)), 32'(m_y_vec(k)));
      end
    end
  end

  task automatic do_frame(input logic [NB-1:0] hv);
    @(posedge clk); #2;
    frame = 1'b1; bullet_hit = hv;
    @(posedge clk); #2;
    frame = 1'b0; bullet_hit = '0;
    @(posedge clk); #2;
  endtask

  task automatic frames(input int n);
    for (int j = 0; j < n; j++) do_frame('0);
  endtask

  // Asserts reset in the middle of a frame pulse and checks the outputs clear without a clock.
  task automatic apply_reset();
    @(posedge clk); #2;
    frame = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_active_slow", 32'(act_s), 32'd0);
    chk("rst_y_slow", 32'(y_s), 32'd0);
    chk("rst_active_fast", 32'(act_f), 32'd0);
    chk("rst_x_fast", 32'(x_f), 32'd0);
    chk("rst_y_fast", 32'(y_f), 32'd0);
    frame = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(posedge clk); #2;
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();

    // Reset, spawn timing and spawn position
    apply_reset();
    chk("lfsr_model_first_step", 32'(m_lfsr[0]), 32'h5670);
    game_active = 1'b1; column_alive = '1; swarm_x = 10'd40; swarm_bottom_y = 10'd200;
    frames(8);
    chk("fast_no_spawn_before_9", 32'(act_f), 32'd0);
    frames(1);
    chk("fast_spawn_frame9", 32'(act_f), 32'd1);
    chk("fast_spawn_y", 32'(dut_y(1, 0)), 32'd200);
    chk("fast_spawn_x", 32'(dut_xs(1, 0)), 32'(40 + m_col[1] * PITCH + XOFF));
    frames(39);
    chk("slow_no_spawn_48", 32'(act_s), 32'd0);
    frames(1);
    chk("slow_spawn_frame49", 32'(act_s), 32'd1);
    chk("slow_spawn_y", 32'(dut_y(0, 0)), 32'd200);
    chk("slow_spawn_x", 32'(dut_xs(0, 0)), 32'(40 + m_col[0] * PITCH + XOFF));
    frames(11);
    chk("slow_one_bullet_60", 32'(act_s), 32'd1);
    chk("slow_y_after_11", 32'(dut_y(0, 0)), 32'd244);

    // Bottom boundary
    apply_reset();
    swarm_bottom_y = 10'd456;
    frames(9);
    chk("b_spawn_456", 32'(dut_y(1, 0)), 32'd456);
    frames(1);
    chk("b_step_to_460_act", 32'(act_f[0]), 32'd1);
    chk("b_step_to_460_y", 32'(dut_y(1, 0)), 32'd460);
    frames(1);
    chk("b_retire_act", 32'(act_f[0]), 32'd0);
    chk("b_retire_y_held", 32'(dut_y(1, 0)), 32'd460);

    // All slots busy, then reuse of retired slot, then hit coinciding with frame
    apply_reset();
    swarm_bottom_y = 10'd0;
    frames(27);
    chk("busy_all3", 32'(act_f), 32'd7);
    chk("busy_y0", 32'(dut_y(1, 0)), 32'd72);
    chk("busy_y1", 32'(dut_y(1, 1)), 32'd36);
    chk("busy_y2", 32'(dut_y(1, 2)), 32'd0);
    frames(97);
    chk("busy_hold_f124", 32'(act_f), 32'd7);
    chk("busy_y0_f124", 32'(dut_y(1, 0)), 32'd460);
    frames(1);
    chk("busy_retire_f125", 32'(act_f), 32'd6);
    chk("busy_retire_y0", 32'(dut_y(1, 0)), 32'd460);
    frames(1);
    chk("busy_respawn_f126", 32'(act_f), 32'd7);
    chk("busy_respawn_y0", 32'(dut_y(1, 0)), 32'd0);
    do_frame(3'b010);
    chk("hit_active", 32'(act_f), 32'd5);
    chk("hit_y0_step", 32'(dut_y(1, 0)), 32'd4);
    chk("hit_y1_frozen", 32'(dut_y(1, 1)), 32'd432);
    chk("hit_y2_step", 32'(dut_y(1, 2)), 32'd400);

    // Dead columns
    apply_reset();
    column_alive = '0;
    frames(18);
    chk("dead_no_spawn_fast", 32'(act_f), 32'd0);
    chk("dead_no_spawn_slow", 32'(act_s), 32'd0);
    column_alive = '1;
    frames(1);
    chk("alive_spawn_next", 32'(act_f), 32'd1);

    // game_active drop
    apply_reset();
    frames(30);
    chk("ga_three_active", 32'(act_f), 32'd7);
    @(posedge clk); #2 game_active = 1'b0;
    @(posedge clk); #2 game_active = 1'b1;
    chk("ga_cleared", 32'(act_f), 32'd0);
    frames(8);
    chk("ga_counter_restart", 32'(act_f), 32'd0);
    frames(1);
    chk("ga_spawn_after_9", 32'(act_f), 32'd1);

`ifdef AIMED_FIRE_EN
    apply_reset();
    swarm_x = 10'd40; player_x = 10'd136; swarm_bottom_y = 10'd0; column_alive = '1;
    for (int s = 0; s < 3; s++) begin
      frames(9);
      @(posedge clk); #2 bullet_hit = 3'b001;
      @(posedge clk); #2 bullet_hit = '0;
    end
    frames(9);
    chk("aimed_active", 32'(act_f), 32'd1);
    chk("aimed_x", 32'(dut_xs(1, 0)), 32'd150);
`endif

    // Randomized traffic against the model
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      if (c % 64 == 0) begin
        swarm_x = 10'($urandom);
        player_x = 10'($urandom);
        swarm_bottom_y = ($urandom % 4 == 0) ? 10'($urandom) : 10'($urandom % 300);
        column_alive = ($urandom % 4 == 0) ? '0 : 11'($urandom);
      end
      frame = ($urandom % 3 == 0);
      bullet_hit = ($urandom % 6 == 0) ? 3'($urandom) : '0;
      game_active = ($urandom % 1500 != 0);
    end
    @(posedge clk); #2;
    frame = 1'b0; bullet_hit = '0; game_active = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
